// File: rtl/mips_boot_ctrl.sv
// Boot controller for the MIPS32 core: streams a program image into CPU memory, runs the core
// until it halts or times out, then streams out the first NUM_DUMP_REGS register values.
module mips_boot_ctrl #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned NUM_DUMP_REGS  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  ld_last,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  cpu_run,
    input  logic                  cpu_halted,
    output logic [REG_ADDR_W-1:0] dump_raddr,
    input  logic [DATA_W-1:0]     dump_rdata,
    output logic                  dmp_valid,
    input  logic                  dmp_ready,
    output logic [REG_ADDR_W-1:0] dmp_idx,
    output logic [DATA_W-1:0]     dmp_data,
    output logic                  dmp_last,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [31:0]           run_cycles
);

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_DUMP_REGS - 1);
    localparam logic [31:0]           TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StRun, StDump, StDone} state_e;

    state_e                  state_q, state_d;
    logic [REG_ADDR_W-1:0]   idx_q;
    logic                    ld_fire, dmp_fire, run_to, start_ok;

    assign ld_fire  = ld_valid & ld_ready;
    assign dmp_fire = dmp_valid & dmp_ready;
    // run_cycles_q holds the RUN cycles already completed, so this is the final allowed cycle
    assign run_to   = (run_cycles == TO_LAST);
    assign start_ok = start & ((state_q == StIdle) | (state_q == StDone));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StLoad;
            StLoad:         if (ld_fire && ld_last) state_d = StFlush;
            StFlush:        state_d = StRun;
            StRun:          if (cpu_halted || run_to) state_d = StDump;
            StDump:         if (dmp_fire && dmp_last) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        ld_ready  = 1'b0;
        cpu_run   = 1'b0;
        dmp_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            StIdle:  busy      = 1'b0;
            StLoad:  ld_ready  = 1'b1;
            StRun:   cpu_run   = 1'b1;
            StDump:  dmp_valid = 1'b1;
            StDone: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign dump_raddr = idx_q;
    assign dmp_idx    = idx_q;
    assign dmp_data   = dmp_valid ? dump_rdata : '0;
    assign dmp_last   = dmp_valid & (idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            run_cycles  <= '0;
            timeout_err <= 1'b0;
            idx_q       <= '0;
        end else begin
            mem_we <= ld_fire;
            if (ld_fire) begin
                mem_waddr <= ld_addr;
                mem_wdata <= ld_data;
            end
            if (start_ok) begin
                run_cycles  <= '0;
                timeout_err <= 1'b0;
                idx_q       <= '0;
            end
            if (state_q == StRun) begin
                if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
                if (!cpu_halted && run_to) timeout_err <= 1'b1;
            end
            if (dmp_fire) idx_q <= dmp_last ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed bench for mips_boot_ctrl: instance a halts via a small core model, instance b
// (TIMEOUT_CYCLES=16) never halts; both share the load/dump streams.
module tb_mips_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        dmp_ready = 1'b0;

    logic        ld_ready_a, mem_we_a, cpu_run_a, halted_a, dmp_valid_a, dmp_last_a;
    logic        busy_a, done_a, terr_a;
    logic [9:0]  waddr_a;
    logic [31:0] wdata_a, rdata_a, dmp_data_a, cyc_a;
    logic [4:0]  raddr_a, dmp_idx_a;

    logic        ld_ready_b, mem_we_b, cpu_run_b, dmp_valid_b, dmp_last_b;
    logic        busy_b, done_b, terr_b;
    logic [9:0]  waddr_b;
    logic [31:0] wdata_b, rdata_b, dmp_data_b, cyc_b;
    logic [4:0]  raddr_b, dmp_idx_b;

    int unsigned runs_a, runs_b;
    int          n_total = 0;
    int          n_pass = 0;
    logic [31:0] img [8];

    always #5 clk = ~clk;

    function automatic logic [31:0] regval(input logic [4:0] r);
        return 32'hC0DE_0000 | ({27'd0, r} * 32'h101);
    endfunction

    assign rdata_a  = regval(raddr_a);
    assign rdata_b  = regval(raddr_b) ^ 32'hFFFF_0000;
    // Core model: HLT executes on its 20th run cycle
    assign halted_a = (runs_a >= 32'd19);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            runs_a <= 0;
            runs_b <= 0;
        end else begin
            if (start && !busy_a) runs_a <= 0;
            else if (cpu_run_a)   runs_a <= runs_a + 1;
            if (start && !busy_b) runs_b <= 0;
            else if (cpu_run_b)   runs_b <= runs_b + 1;
        end
    end

    mips_boot_ctrl #(.TIMEOUT_CYCLES(1000)) dut_a (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .mem_we(mem_we_a),
        .mem_waddr(waddr_a), .mem_wdata(wdata_a), .cpu_run(cpu_run_a), .cpu_halted(halted_a),
        .dump_raddr(raddr_a), .dump_rdata(rdata_a), .dmp_valid(dmp_valid_a),
        .dmp_ready(dmp_ready), .dmp_idx(dmp_idx_a), .dmp_data(dmp_data_a),
        .dmp_last(dmp_last_a), .busy(busy_a), .done(done_a), .timeout_err(terr_a),
        .run_cycles(cyc_a)
    );

    mips_boot_ctrl #(.TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .mem_we(mem_we_b),
        .mem_waddr(waddr_b), .mem_wdata(wdata_b), .cpu_run(cpu_run_b), .cpu_halted(1'b0),
        .dump_raddr(raddr_b), .dump_rdata(rdata_b), .dmp_valid(dmp_valid_b),
        .dmp_ready(dmp_ready), .dmp_idx(dmp_idx_b), .dmp_data(dmp_data_b),
        .dmp_last(dmp_last_b), .busy(busy_b), .done(done_b), .timeout_err(terr_b),
        .run_cycles(cyc_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cpu_run"}, cpu_run_a, 1'b0);
        check({tag, "_mem_we"}, mem_we_a, 1'b0);
        check({tag, "_waddr"}, waddr_a, 10'd0);
        check({tag, "_ld_ready"}, ld_ready_a, 1'b0);
        check({tag, "_dmp_valid"}, dmp_valid_a, 1'b0);
        check({tag, "_dmp_data"}, dmp_data_a, 32'd0);
        check({tag, "_busy"}, busy_a, 1'b0);
        check({tag, "_done"}, done_a, 1'b0);
        check({tag, "_terr"}, terr_a, 1'b0);
        check({tag, "_cycles"}, cyc_a, 32'd0);
    endtask

    // Called at the negedge where the FSM has just entered LOAD; returns in the first RUN cycle.
    task automatic load_image();
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 10'(i);
            ld_data  = img[i];
            ld_last  = (i == 7);
            start    = (i == 3);
            check("ld_ready", ld_ready_a, 1'b1);
            if (i > 0) begin
                check("mem_we", mem_we_a, 1'b1);
                check("mem_waddr", waddr_a, 10'(i - 1));
                check("mem_wdata", wdata_a, img[i - 1]);
            end else begin
                check("mem_we_first", mem_we_a, 1'b0);
            end
            @(negedge clk);
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("flush_mem_we", mem_we_a, 1'b1);
        check("flush_waddr", waddr_a, 10'd7);
        check("flush_wdata", wdata_a, img[7]);
        check("flush_cpu_run", cpu_run_a, 1'b0);
        check("flush_ld_ready", ld_ready_a, 1'b0);
        @(negedge clk);
        check("run_mem_we", mem_we_a, 1'b0);
        check("run_cpu_run", cpu_run_a, 1'b1);
        check("run_busy", busy_a, 1'b1);
    endtask

    task automatic wait_dump();
        int n = 0;
        while (!dmp_valid_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("dump_reached", dmp_valid_a, 1'b1);
        check("halt_cycles", cyc_a, 32'd20);
        check("halt_runs", runs_a, 32'd20);
        check("halt_terr", terr_a, 1'b0);
        check("dump_cpu_run", cpu_run_a, 1'b0);
        check("to_runs", runs_b, 32'd16);
        check("to_cycles", cyc_b, 32'd16);
        check("to_terr", terr_b, 1'b1);
        check("to_dmp_valid", dmp_valid_b, 1'b1);
    endtask

    task automatic do_dump(input bit stall);
        for (int k = 0; k < 8; k++) begin
            if (stall && k == 3) begin
                dmp_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", dmp_valid_a, 1'b1);
                    check("stall_idx", dmp_idx_a, 5'd3);
                    check("stall_data", dmp_data_a, regval(5'd3));
                end
            end
            check("dmp_valid", dmp_valid_a, 1'b1);
            check("dmp_idx", dmp_idx_a, 5'(k));
            check("dump_raddr", raddr_a, 5'(k));
            check("dmp_data", dmp_data_a, regval(5'(k)));
            check("dmp_last", dmp_last_a, k == 7);
            check("dmp_idx_b", dmp_idx_b, 5'(k));
            check("dmp_data_b", dmp_data_b, regval(5'(k)) ^ 32'hFFFF_0000);
            dmp_ready = 1'b1;
            @(negedge clk);
        end
        dmp_ready = 1'b0;
        check("done", done_a, 1'b1);
        check("done_busy", busy_a, 1'b0);
        check("done_dmp_valid", dmp_valid_a, 1'b0);
        check("done_b", done_b, 1'b1);
    endtask

    initial begin
        img[0] = 32'h2001_0005;  // ADDI r1,r0,5
        img[1] = 32'h0021_1022;  // SUB  r2,r1,r1
        img[2] = 32'h8C03_0000;  // LW   r3,0(r0)
        img[3] = 32'h0023_2020;  // ADD  r4,r1,r3
        img[4] = 32'h1040_0001;  // BEQZ r2,+1
        img[5] = 32'h2005_0001;  // ADDI r5,r0,1
        img[6] = 32'h2006_0002;  // ADDI r6,r0,2
        img[7] = 32'hFC00_0000;  // HLT

        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Round 1: load, ignored start/ld_valid in RUN, halt vs timeout, stalled dump
        start = 1'b1;
        @(negedge clk);
        load_image();
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("run_ign_mem_we", mem_we_a, 1'b0);
            check("run_ign_cpu_run", cpu_run_a, 1'b1);
            check("run_ign_ld_ready", ld_ready_a, 1'b0);
        end
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        wait_dump();
        do_dump(1'b1);

        // Round 2: restart from DONE clears stats, then reset 3 cycles into RUN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_cycles", cyc_a, 32'd0);
        check("restart_terr_b", terr_b, 1'b0);
        check("restart_ld_ready", ld_ready_a, 1'b1);
        start = 1'b1;
        load_image();
        repeat (2) @(negedge clk);
        check("pre_rst_cpu_run", cpu_run_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_rst");

        // Round 3: clean reload after reset
        start = 1'b1;
        @(negedge clk);
        load_image();
        wait_dump();
        do_dump(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1);
    end

endmodule
